// File: rtl/drr_pkg.sv
// Shared types and default sizing for the deficit round robin scheduler.
package drr_pkg;

  localparam int DRR_CHANNELS  = 8;
  localparam int DRR_WIDTH     = 32;
  localparam int DRR_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SEND  = 2'd2,
    ST_CHECK = 2'd3
  } drr_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// Per-channel deficit registers. The register selected by sel can get a
// saturating add, a length subtract when the sum covers the length, or a clear.
module drr_deficit_bank
  import drr_pkg::*;
#(
  parameter int CHANNELS  = DRR_CHANNELS,
  parameter int WIDTH     = DRR_WIDTH,
  parameter int LEN_WIDTH = DRR_LEN_WIDTH,
  parameter int PTR_W     = ptr_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PTR_W-1:0]     sel,
  input  logic [WIDTH-1:0]     add_val,
  input  logic [LEN_WIDTH-1:0] len_val,
  input  logic                 clr_en,
  input  logic                 upd_en,
  output logic                 fits
);

  localparam int CW = (WIDTH > LEN_WIDTH) ? WIDTH : LEN_WIDTH;

  logic [WIDTH-1:0] deficit_reg [CHANNELS];
  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] new_val;
  logic [CW-1:0]    sum_ext;
  logic [CW-1:0]    len_ext;

  assign sum_wide = {1'b0, deficit_reg[sel]} + {1'b0, add_val};
  assign sum      = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
  assign sum_ext  = CW'(sum);
  assign len_ext  = CW'(len_val);
  assign fits     = (sum_ext >= len_ext);
  // When fits is set the length is no larger than sum, so narrowing it is lossless.
  assign new_val  = fits ? (sum - WIDTH'(len_val)) : sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) deficit_reg[i] <= '0;
    end else if (clr_en) begin
      deficit_reg[sel] <= '0;
    end else if (upd_en) begin
      deficit_reg[sel] <= new_val;
    end
  end

endmodule

// File: rtl/drr_scheduler.sv
// Deficit round robin scheduler granting one channel's packet at a time.
// Optional DRR_STATS_EN adds per-channel completed-packet counters (pkt_count).
module drr_scheduler
  import drr_pkg::*;
#(
  parameter int CHANNELS  = DRR_CHANNELS,
  parameter int WIDTH     = DRR_WIDTH,
  parameter int LEN_WIDTH = DRR_LEN_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           req_valid,
  input  logic [CHANNELS*LEN_WIDTH-1:0] req_len,
  input  logic [CHANNELS*WIDTH-1:0]     quantum,
  input  logic                          beat_ready,
  output logic                          beat_valid,
  output logic [CHANNELS-1:0]           grant,
  output logic                          pkt_last,
  output logic [CHANNELS-1:0]           pkt_done
`ifdef DRR_STATS_EN
  ,
  output logic [CHANNELS*32-1:0]        pkt_count
`endif
);

  localparam int PW = ptr_width(CHANNELS);
  localparam logic [PW-1:0] P_LAST = PW'(CHANNELS - 1);

  drr_state_e           state_reg, state_next;
  logic [PW-1:0]        p_reg, p_next, p_inc;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;

  logic [LEN_WIDTH-1:0] len_arr     [CHANNELS];
  logic [WIDTH-1:0]     quantum_arr [CHANNELS];
  logic [CHANNELS-1:0]  p_onehot;
  logic [LEN_WIDTH-1:0] len_p, eff_len_p;
  logic [WIDTH-1:0]     add_val;
  logic                 clr_en, upd_en, fits;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign len_arr[gi]     = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
    assign quantum_arr[gi] = quantum[gi*WIDTH +: WIDTH];
    assign p_onehot[gi]    = (p_reg == PW'(gi));
  end

  assign len_p     = len_arr[p_reg];
  assign eff_len_p = (len_p == '0) ? LEN_WIDTH'(1) : len_p;
  assign p_inc     = (p_reg == P_LAST) ? '0 : p_reg + PW'(1);

  drr_deficit_bank #(
    .CHANNELS  (CHANNELS),
    .WIDTH     (WIDTH),
    .LEN_WIDTH (LEN_WIDTH),
    .PTR_W     (PW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .sel     (p_reg),
    .add_val (add_val),
    .len_val (eff_len_p),
    .clr_en  (clr_en),
    .upd_en  (upd_en),
    .fits    (fits)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      p_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    add_val    = '0;
    clr_en     = 1'b0;
    upd_en     = 1'b0;
    beat_valid = 1'b0;
    grant      = '0;
    pkt_last   = 1'b0;
    pkt_done   = '0;

    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) state_next = ST_SCAN;
      end

      ST_SCAN: begin
        if (!(|req_valid)) begin
          state_next = ST_IDLE;
        end else if (!req_valid[p_reg]) begin
          clr_en = 1'b1;
          p_next = p_inc;
        end else begin
          add_val = quantum_arr[p_reg];
          upd_en  = 1'b1;
          if (fits) begin
            cnt_next   = eff_len_p;
            state_next = ST_SEND;
          end else begin
            p_next = p_inc;
          end
        end
      end

      // Only p and the beat counter steer SEND, so the packet is committed.
      ST_SEND: begin
        grant      = p_onehot;
        beat_valid = 1'b1;
        pkt_last   = (cnt_reg == LEN_WIDTH'(1));
        if (beat_ready) begin
          cnt_next = cnt_reg - LEN_WIDTH'(1);
          if (pkt_last) begin
            pkt_done   = p_onehot;
            state_next = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (req_valid[p_reg] && fits) begin
          upd_en     = 1'b1;
          cnt_next   = eff_len_p;
          state_next = ST_SEND;
        end else begin
          clr_en     = !req_valid[p_reg];
          p_next     = p_inc;
          state_next = ST_SCAN;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

`ifdef DRR_STATS_EN
  logic [31:0] pkt_count_reg [CHANNELS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) pkt_count_reg[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (pkt_done[i]) pkt_count_reg[i] <= pkt_count_reg[i] + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stats
    assign pkt_count[gi*32 +: 32] = pkt_count_reg[gi];
  end
`endif

endmodule

// File: tb/tb_drr_scheduler.sv
// Directed bench for drr_scheduler with 4 channels, 8-bit deficits and lengths.
module tb_drr_scheduler;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [CH-1:0]   req_valid = '0;
  logic [CH*LW-1:0] req_len = '0;
  logic [CH*W-1:0] quantum = '0;
  logic            beat_ready = 1'b1;
  logic            beat_valid;
  logic [CH-1:0]   grant;
  logic            pkt_last;
  logic [CH-1:0]   pkt_done;
`ifdef DRR_STATS_EN
  logic [CH*32-1:0] pkt_count;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  drr_scheduler #(.CHANNELS(CH), .WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_len    (req_len),
    .quantum    (quantum),
    .beat_ready (beat_ready),
    .beat_valid (beat_valid),
    .grant      (grant),
    .pkt_last   (pkt_last),
    .pkt_done   (pkt_done)
`ifdef DRR_STATS_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [LW-1:0] len, input logic [W-1:0] q);
    req_len[ch*LW +: LW] = len;
    quantum[ch*W +: W]   = q;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    beat_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!beat_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " start"}, 32'(beat_valid), 32'd1);
  endtask

  // Leaves the caller in the handshake cycle of the last beat.
  task automatic run_packet(input string tag, input logic [CH-1:0] exp_grant,
                            input int exp_beats, input bit drop);
    int  n = 0;
    int  beats = 0;
    bit  done = 1'b0;
    wait_valid(tag);
    if (beat_valid) begin
      check({tag, " grant"}, 32'(grant), 32'(exp_grant));
      while (!done && n < exp_beats + 8) begin
        if (beat_valid && beat_ready) beats++;
        if (pkt_done != '0) begin
          done = 1'b1;
          check({tag, " pkt_done"}, 32'(pkt_done), 32'(exp_grant));
          check({tag, " pkt_last"}, 32'(pkt_last), 32'd1);
          if (drop) req_valid = '0;
        end else begin
          tick();
          n++;
        end
      end
      check({tag, " beats"}, 32'(beats), 32'(exp_beats));
    end
  endtask

  initial begin
    int beats;
    int dones;

    for (int c = 0; c < CH; c++) set_ch(c, 8'd1, 8'd4);
    tick();
    tick();
    check("reset grant", 32'(grant), 32'd0);
    check("reset beat_valid", 32'(beat_valid), 32'd0);
    check("reset pkt_done", 32'(pkt_done), 32'd0);
    check("reset pkt_last", 32'(pkt_last), 32'd0);
    reset = 1'b1;
    tick();

    // DRR order plus first-visit latency
    set_ch(0, 8'd3, 8'd4);
    set_ch(2, 8'd6, 8'd4);
    req_valid = 4'b0101;
    check("lat cycle N", 32'(beat_valid), 32'd0);
    tick();
    check("lat cycle N+1", 32'(beat_valid), 32'd0);
    tick();
    check("lat cycle N+2", 32'(beat_valid), 32'd1);
    run_packet("drr ch0 first", 4'b0001, 3, 1'b0);
    check("drr def0 after first", 32'(dut.u_bank.deficit_reg[0]), 32'd1);
    tick();
    run_packet("drr ch0 second", 4'b0001, 3, 1'b0);
    check("drr def0 after second", 32'(dut.u_bank.deficit_reg[0]), 32'd2);
    check("drr def2 skipped", 32'(dut.u_bank.deficit_reg[2]), 32'd4);
    tick();
    run_packet("drr ch2", 4'b0100, 6, 1'b1);
    check("drr def2 after send", 32'(dut.u_bank.deficit_reg[2]), 32'd2);
    do_reset();

    // Back-to-back on ch1 through CHECK
    set_ch(1, 8'd4, 8'd10);
    req_valid = 4'b0010;
    run_packet("b2b first", 4'b0010, 4, 1'b0);
    check("b2b def1 mid", 32'(dut.u_bank.deficit_reg[1]), 32'd6);
    tick();
    check("b2b check gap", 32'(beat_valid), 32'd0);
    tick();
    check("b2b regrant", 32'(grant), 32'b0010);
    run_packet("b2b second", 4'b0010, 4, 1'b1);
    check("b2b def1 end", 32'(dut.u_bank.deficit_reg[1]), 32'd2);
    do_reset();

    // Backpressure mid-packet
    set_ch(3, 8'd5, 8'd8);
    req_valid = 4'b1000;
    wait_valid("bp");
    check("bp grant", 32'(grant), 32'b1000);
    tick();
    tick();
    beat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp hold grant", 32'(grant), 32'b1000);
      check("bp hold valid", 32'(beat_valid), 32'd1);
      check("bp hold count", 32'(dut.cnt_reg), 32'd3);
      check("bp no done", 32'(pkt_done), 32'd0);
      tick();
    end
    beat_ready = 1'b1;
    beats = 0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (beat_valid && beat_ready) beats++;
      if (pkt_done != '0) begin
        dones++;
        req_valid = '0;
      end
      tick();
    end
    check("bp remaining beats", 32'(beats), 32'd3);
    check("bp done count", 32'(dones), 32'd1);
    do_reset();

    // Reset during beat 2 of 5
    set_ch(2, 8'd5, 8'd8);
    req_valid = 4'b0100;
    wait_valid("rst");
    check("rst grant before", 32'(grant), 32'b0100);
    tick();
    reset = 1'b0;
    #1;
    check("rst grant now", 32'(grant), 32'd0);
    check("rst beat_valid now", 32'(beat_valid), 32'd0);
    check("rst def2 cleared", 32'(dut.u_bank.deficit_reg[2]), 32'd0);
    check("rst count cleared", 32'(dut.cnt_reg), 32'd0);
    set_ch(0, 8'd3, 8'd4);
    req_valid = 4'b0101;
    tick();
    tick();
    reset = 1'b1;
    run_packet("rst first after", 4'b0001, 3, 1'b1);
    do_reset();

    // Zero length is one beat
    set_ch(1, 8'd0, 8'd4);
    req_valid = 4'b0010;
    wait_valid("len0");
    check("len0 grant", 32'(grant), 32'b0010);
    check("len0 pkt_last", 32'(pkt_last), 32'd1);
    check("len0 pkt_done", 32'(pkt_done), 32'b0010);
    check("len0 def1", 32'(dut.u_bank.deficit_reg[1]), 32'd3);
    req_valid = '0;
    tick();
    check("len0 one beat only", 32'(beat_valid), 32'd0);
    do_reset();

    // Saturation: deficit 200 plus quantum 255 clamps to 255
    set_ch(0, 8'd55, 8'd255);
    req_valid = 4'b0001;
    run_packet("sat first", 4'b0001, 55, 1'b0);
    check("sat def0 200", 32'(dut.u_bank.deficit_reg[0]), 32'd200);
    set_ch(0, 8'd250, 8'd255);
    tick();
    run_packet("sat second", 4'b0001, 250, 1'b1);
    check("sat def0 5", 32'(dut.u_bank.deficit_reg[0]), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
